// File: rtl/aes_round_pipe.sv
// aes_round_pipe: LANES independent AES rounds (full or final) behind an
// elastic valid/ready pipeline of PIPE (1 or 2) register stages.
// Byte 0 of a lane is bits [127:120]; 32-bit words are state columns.
module aes_round_pipe #(
  parameter int LANES = 2,
  parameter int PIPE  = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [128*LANES-1:0] in_data,
  input  logic [128*LANES-1:0] in_key,
  input  logic                 in_final,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [128*LANES-1:0] out_data,
  output logic                 out_final
);

  localparam int W = 128 * LANES;

  // Forward AES S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // SubBytes followed by ShiftRows: row r of column c comes from column c+r.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int rw = 0; rw < 4; rw++) begin
        r[127 - 8*(rw + 4*c) -: 8] = sbox(s[127 - 8*(rw + 4*((c + rw) % 4)) -: 8]);
      end
    end
    return r;
  endfunction

  // MixColumns with the circulant [2 3 1 1] applied to each column.
  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      r[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  // SubBytes+ShiftRows of the incoming state, one instance per lane.
  logic [W-1:0] sr_in;
  for (genvar gi = 0; gi < LANES; gi++) begin : g_sr
    assign sr_in[128*gi +: 128] = sub_shift(in_data[128*gi +: 128]);
  end

  // Output stage registers (last pipeline stage in both configurations).
  logic         out_v_q, out_v_d;
  logic         out_fin_q, out_fin_d;
  logic [W-1:0] out_data_q, out_data_d;

  if (PIPE == 2) begin : g_pipe2
    logic         a_v_q, a_v_d;
    logic         a_fin_q, a_fin_d;
    logic [W-1:0] a_sr_q, a_sr_d;
    logic [W-1:0] a_key_q, a_key_d;
    logic [W-1:0] b_round;
    logic         adv_a, adv_b, accept, load_b;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign b_round[128*gi +: 128] =
        (a_fin_q ? a_sr_q[128*gi +: 128] : mix_columns(a_sr_q[128*gi +: 128]))
        ^ a_key_q[128*gi +: 128];
    end

    // Stage advance chain; flush empties both stages without touching data.
    always_comb begin
      adv_b      = !out_v_q || out_ready;
      adv_a      = !a_v_q || adv_b;
      in_ready   = adv_a && !flush;
      accept     = in_valid && in_ready;
      load_b     = adv_b && a_v_q && !flush;
      a_v_d      = flush ? 1'b0 : (adv_a ? accept : a_v_q);
      out_v_d    = flush ? 1'b0 : (adv_b ? a_v_q : out_v_q);
      a_sr_d     = accept ? sr_in : a_sr_q;
      a_key_d    = accept ? in_key : a_key_q;
      a_fin_d    = accept ? in_final : a_fin_q;
      out_data_d = load_b ? b_round : out_data_q;
      out_fin_d  = load_b ? a_fin_q : out_fin_q;
    end

    // Stage A registers: substituted/shifted state, key and final flag.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        a_v_q   <= 1'b0;
        a_fin_q <= 1'b0;
        a_sr_q  <= '0;
        a_key_q <= '0;
      end else begin
        a_v_q   <= a_v_d;
        a_fin_q <= a_fin_d;
        a_sr_q  <= a_sr_d;
        a_key_q <= a_key_d;
      end
    end
  end else begin : g_pipe1
    logic [W-1:0] round_in;
    logic         adv, accept;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign round_in[128*gi +: 128] =
        (in_final ? sr_in[128*gi +: 128] : mix_columns(sr_in[128*gi +: 128]))
        ^ in_key[128*gi +: 128];
    end

    // Single stage: the whole round lands in the output register.
    always_comb begin
      adv        = !out_v_q || out_ready;
      in_ready   = adv && !flush;
      accept     = in_valid && in_ready;
      out_v_d    = flush ? 1'b0 : (adv ? accept : out_v_q);
      out_data_d = accept ? round_in : out_data_q;
      out_fin_d  = accept ? in_final : out_fin_q;
    end
  end

  // Output stage registers, cleared by reset so nothing partial escapes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_v_q    <= 1'b0;
      out_fin_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      out_v_q    <= out_v_d;
      out_fin_q  <= out_fin_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_valid = out_v_q;
  assign out_data  = out_data_q;
  assign out_final = out_fin_q;

endmodule

// File: tb/tb_aes_round_pipe.sv
// tb_aes_round_pipe: directed FIPS-197 vectors, backpressure, streaming,
// flush and reset checks against a GF(2^8)-derived reference model.
module tb_aes_round_pipe;
  localparam int LANES = 2;
  localparam int PIPE  = 2;
  localparam int W     = 128 * LANES;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_final = 1'b0;
  logic         flush = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic [W-1:0] in_key = '0;
  logic         in_ready, out_valid, out_final;
  logic [W-1:0] out_data;

  int n_vec = 0;
  int n_err = 0;
  int got = 0;
  logic [W:0] sb[$];
  logic [W:0] stall_data = '0;
  bit         stall_v = 1'b0;
  logic [7:0] msb[256];

  aes_round_pipe #(.LANES(LANES), .PIPE(PIPE)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_key(in_key), .in_final(in_final), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_final(out_final)
  );

  always #5 clk = ~clk;

  // Reference model built from field arithmetic, not from a table.
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] m_sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gm(inv, x);
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] model_lane(input logic [127:0] d, input logic [127:0] k,
                                              input logic f);
    logic [7:0]   a[16];
    logic [7:0]   b[16];
    logic [127:0] res;
    for (int i = 0; i < 16; i++) a[i] = msb[d[127 - 8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) b[r + 4*c] = a[r + 4*((c + r) % 4)];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        a[r + 4*c] = f ? b[r + 4*c] :
          gm(8'h02, b[r + 4*c]) ^ gm(8'h03, b[(r + 1) % 4 + 4*c]) ^
          b[(r + 2) % 4 + 4*c] ^ b[(r + 3) % 4 + 4*c];
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = a[i] ^ k[127 - 8*i -: 8];
    return res;
  endfunction

  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [W-1:0] k,
                                         input logic f);
    logic [W-1:0] r;
    for (int l = 0; l < LANES; l++)
      r[128*l +: 128] = model_lane(d[128*l +: 128], k[128*l +: 128], f);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One handshake cycle with scoreboard and stall-stability checks.
  task automatic cycle(output bit acc, output bit ir, output bit ov);
    logic [W:0] exp_v;
    #1;
    ir  = in_ready;
    ov  = out_valid;
    acc = in_valid && in_ready;
    if (out_valid && stall_v) chk("stall_hold", {out_final, out_data}, stall_data);
    stall_v    = out_valid && !out_ready;
    stall_data = {out_final, out_data};
    if (out_valid && out_ready) begin
      if (sb.size() == 0) chk_int("unexpected_out", int'(out_valid), 0);
      else begin
        exp_v = sb.pop_front();
        chk("out_txn", {out_final, out_data}, exp_v);
        got++;
      end
    end
    if (acc) sb.push_back({in_final, model(in_data, in_key, in_final)});
    tick();
  endtask

  // Single transaction into an empty pipe, checking exact latency.
  task automatic directed(input string tag, input logic [W-1:0] d, input logic [W-1:0] k,
                          input logic f, input logic [W:0] exp_v);
    in_data = d; in_key = k; in_final = f; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk_int({tag, "_in_ready"}, int'(in_ready), 1);
    tick();
    in_valid = 1'b0; in_data = '0; in_key = '0; in_final = 1'b0;
    chk_int({tag, "_lat1_valid"}, int'(out_valid), 0);
    tick();
    chk_int({tag, "_valid"}, int'(out_valid), 1);
    chk({tag, "_data"}, {out_final, out_data}, exp_v);
    tick();
    chk_int({tag, "_drained"}, int'(out_valid), 0);
  endtask

  initial begin
    bit acc, ir, ov;
    int sent, acc_stall, ir_low, gaps, cnt;
    logic [7:0] bv;

    for (int i = 0; i < 256; i++) msb[i] = m_sbox(8'(i));

    // Reset state
    reset_n = 1'b0;
    tick(); tick();
    chk_int("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", {out_final, out_data}, '0);
    reset_n = 1'b1;
    tick();
    chk_int("rst_in_ready", int'(in_ready), 1);

    // Test 1: FIPS-197 round 1 in lane 0, zero state/key in lane 1
    directed("t1", {128'h0, 128'h193de3bea0f4e22b9ac68d2ae9f84808},
             {128'h0, 128'ha0fafe1788542cb123a339392a6c7605}, 1'b0,
             {1'b0, {16{8'h63}}, 128'ha49c7ff2689f352b6b5bea43026a5049});

    // Test 2: final round (no MixColumns)
    directed("t2", {128'h0, 128'heb40f21e592e38848ba113e71bc342d2},
             {128'h0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6}, 1'b1,
             {1'b1, {16{8'h63}}, 128'h3925841d02dc09fbdc118597196a0b32});

    // Test 3: zero-key lanes, vector in lane 1
    directed("t3", {128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'h0}, '0, 1'b0,
             {1'b0, 128'h046681e5e0cb199a48f8d37a2806264c, {16{8'h63}}});

    // Test 4: backpressure, out_ready low for 4 cycles
    sent = 0; acc_stall = 0; ir_low = 0; gaps = 0; got = 0;
    for (int c = 0; c < 14; c++) begin
      out_ready = (c >= 4);
      in_valid  = (sent < 5);
      bv        = 8'(17 * (sent + 1));
      in_data   = {32{bv}};
      in_key    = {32{bv ^ 8'h5a}};
      in_final  = sent[0];
      cycle(acc, ir, ov);
      if (acc) begin
        sent++;
        if (!out_ready) acc_stall++;
      end
      if ((c == 2 || c == 3) && !ir) ir_low++;
      if (c >= 4 && c <= 8 && !ov) gaps++;
    end
    in_valid = 1'b0;
    chk_int("t4_accepts_in_stall", acc_stall, PIPE);
    chk_int("t4_in_ready_low", ir_low, 2);
    chk_int("t4_no_gaps", gaps, 0);
    chk_int("t4_outputs", got, 5);

    // Test 5: full throughput with random vectors
    got = 0; ir_low = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      for (int j = 0; j < W/32; j++) begin
        in_data[32*j +: 32] = $urandom();
        in_key[32*j +: 32]  = $urandom();
      end
      in_final = 1'($urandom_range(0, 1));
      cycle(acc, ir, ov);
      if (!ir) ir_low++;
    end
    in_valid = 1'b0;
    for (int c = 0; c < PIPE + 2; c++) cycle(acc, ir, ov);
    chk_int("t5_in_ready_low", ir_low, 0);
    chk_int("t5_outputs", got, 20);
    chk_int("t5_sb_empty", sb.size(), 0);

    // Test 6a: flush with two transactions in flight
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = {8{32'hc0de0000 + i}}; in_key = '0; in_final = 1'b0;
      cycle(acc, ir, ov);
    end
    flush = 1'b1; in_data = {8{32'hdeadbeef}};
    #1 chk_int("t6_flush_blocks_in", int'(in_ready), 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    sb.delete(); stall_v = 1'b0;
    chk_int("t6_flush_clears", int'(out_valid), 0);
    out_ready = 1'b1; cnt = 0;
    for (int c = 0; c < 4; c++) begin
      cycle(acc, ir, ov);
      if (ov) cnt++;
    end
    chk_int("t6_no_stale_flush", cnt, 0);

    // Test 6b: reset with two transactions in flight
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = {8{32'h5eed0000 + i}}; in_key = {8{32'h1}}; in_final = 1'b1;
      cycle(acc, ir, ov);
    end
    in_valid = 1'b0; reset_n = 1'b0;
    tick();
    chk_int("t6_rst_valid", int'(out_valid), 0);
    chk("t6_rst_data", {out_final, out_data}, '0);
    tick();
    reset_n = 1'b1;
    sb.delete(); stall_v = 1'b0;
    tick();
    chk_int("t6_rst_in_ready", int'(in_ready), 1);
    out_ready = 1'b1; cnt = 0;
    for (int c = 0; c < 3; c++) begin
      cycle(acc, ir, ov);
      if (ov) cnt++;
    end
    chk_int("t6_no_stale_rst", cnt, 0);
    directed("t6_resume", {128'h0, 128'h193de3bea0f4e22b9ac68d2ae9f84808},
             {128'h0, 128'ha0fafe1788542cb123a339392a6c7605}, 1'b0,
             {1'b0, {16{8'h63}}, 128'ha49c7ff2689f352b6b5bea43026a5049});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
